mac_driver: RTL



---
 rtl/mac_pkg.sv | 30 +++
 rtl/mac_drv_counter.sv | 44 ++++
 rtl/mac_driver.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC initiator-side driver.
//   mac_state_e  : sequencer states
//   DataWidth    : operand / result width
//   AddrWidth    : operand SRAM address width
//   CountWidth   : job-length counter width (holds 1..256)
//   FloatIntFp / FloatIntInt : MAC data-type encoding
//   job_len()    : expands the 8-bit length field (0 means 256)
package mac_pkg;

    localparam int unsigned DataWidth  = 16;
    localparam int unsigned AddrWidth  = 8;
    localparam int unsigned CountWidth = AddrWidth + 1;

    localparam logic FloatIntFp  = 1'b1;
    localparam logic FloatIntInt = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StConf,
        StStream,
        StDrain,
        StResult
    } mac_state_e;

    // A zero length field encodes 256 pairs.
    function automatic logic [CountWidth-1:0] job_len(input logic [AddrWidth-1:0] len);
        return {(len == '0), len};
    endfunction

endpackage

// File: rtl/mac_drv_counter.sv
// Loadable up-counter with terminal compare.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i (takes priority over inc_i)
//   load_val_i  : load value
//   inc_i       : increment by one
//   term_i      : terminal value to compare against
//   count_o     : current count
//   term_o      : count_o == term_i
module mac_drv_counter #(
    parameter int unsigned Width = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             inc_i,
    input  logic [Width-1:0] term_i,
    output logic [Width-1:0] count_o,
    output logic             term_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == term_i);

endmodule

// File: rtl/mac_driver.sv
// Job sequencer feeding operand pairs from a dual-output SRAM into a MAC.
//   cmd_*        : job descriptor (base, length with 0 = 256, data type), ready/valid
//   rd_*         : SRAM read port; rd_data is captured at the edge closing the rd_en cycle
//   config_en, float_int, data_num : MAC configuration
//   in_a, in_b, in_valid_a, in_valid_b : MAC operand stream
//   out_valid, mac_out : MAC partial-result strobe and value
//   res_*        : final result, ready/valid; res_timeout flags an aborted job
module mac_driver
    import mac_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned CONF_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [AddrWidth-1:0] cmd_base,
    input  logic [AddrWidth-1:0] cmd_len,
    input  logic                 cmd_float_int,
    output logic                 rd_en,
    output logic [AddrWidth-1:0] rd_addr,
    input  logic [DataWidth-1:0] rd_data_a,
    input  logic [DataWidth-1:0] rd_data_b,
    output logic                 config_en,
    output logic                 float_int,
    output logic [AddrWidth-1:0] data_num,
    output logic [DataWidth-1:0] in_a,
    output logic [DataWidth-1:0] in_b,
    output logic                 in_valid_a,
    output logic                 in_valid_b,
    input  logic                 out_valid,
    input  logic [DataWidth-1:0] mac_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DataWidth-1:0] res_data,
    output logic                 res_timeout
);

    localparam int unsigned IdleWidth = $clog2(TIMEOUT + 1);

    mac_state_e           state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic [AddrWidth-1:0] base_q, base_d, len_q, len_d;
    logic                 float_int_q, float_int_d;
    logic [DataWidth-1:0] res_data_q, res_data_d;
    logic                 res_timeout_q, res_timeout_d;
    logic [DataWidth-1:0] in_a_q, in_a_d, in_b_q, in_b_d;
    logic                 in_valid_q, in_valid_d;

    logic                  accept;
    logic [CountWidth-1:0] job_n;

    logic                  issue_load, issue_inc, issue_term;
    logic [CountWidth-1:0] issue_cnt, issue_term_val;
    logic                  unused_issue_msb;

    logic                  pulse_load, pulse_inc, pulse_term, pulse_done, pulse_final;
    logic [CountWidth-1:0] pulse_cnt;

    logic                  idle_load, idle_inc, idle_term, timed_out;
    logic [IdleWidth-1:0]  unused_idle_cnt;

    assign accept = cmd_valid & cmd_ready_q;
    assign job_n  = job_len(len_q);

    // Issue index doubles as the CONF dwell counter; it is reloaded on entry to STREAM.
    assign issue_load     = (state_q == StIdle) | ((state_q == StConf) & issue_term);
    assign issue_inc      = (state_q == StConf) | (state_q == StStream);
    assign issue_term_val = (state_q == StConf) ? CountWidth'(CONF_CYCLES - 1)
                                                : job_n - CountWidth'(1);

    mac_drv_counter #(.Width(CountWidth)) u_issue_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (issue_load),
        .load_val_i ('0),
        .inc_i      (issue_inc),
        .term_i     (issue_term_val),
        .count_o    (issue_cnt),
        .term_o     (issue_term)
    );
    assign unused_issue_msb = issue_cnt[CountWidth-1];

    // Pulses are only counted while a job is streaming or draining, and never past N.
    assign pulse_load  = (state_q == StIdle);
    assign pulse_done  = (pulse_cnt == job_n);
    assign pulse_inc   = out_valid & ((state_q == StStream) | (state_q == StDrain)) & ~pulse_done;
    assign pulse_final = pulse_done | (pulse_inc & pulse_term);

    mac_drv_counter #(.Width(CountWidth)) u_pulse_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (pulse_load),
        .load_val_i ('0),
        .inc_i      (pulse_inc),
        .term_i     (job_n - CountWidth'(1)),
        .count_o    (pulse_cnt),
        .term_o     (pulse_term)
    );

    // Consecutive quiet DRAIN cycles; the TIMEOUT-th one ends the job.
    assign idle_load = (state_q != StDrain) | out_valid;
    assign idle_inc  = (state_q == StDrain);
    assign timed_out = (state_q == StDrain) & idle_term & ~out_valid;

    mac_drv_counter #(.Width(IdleWidth)) u_idle_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (idle_load),
        .load_val_i ('0),
        .inc_i      (idle_inc),
        .term_i     (IdleWidth'(TIMEOUT - 1)),
        .count_o    (unused_idle_cnt),
        .term_o     (idle_term)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept)                   state_d = StConf;
            StConf:   if (issue_term)               state_d = StStream;
            StStream: if (issue_term)               state_d = StDrain;
            StDrain:  if (pulse_final || timed_out) state_d = StResult;
            StResult: if (res_ready)                state_d = StIdle;
            default:                                state_d = StIdle;
        endcase
    end

    // Output decode.
    always_comb begin
        config_en = (state_q == StConf);
        rd_en     = (state_q == StStream);
        res_valid = (state_q == StResult);
        rd_addr   = rd_en ? base_q + issue_cnt[AddrWidth-1:0] : '0;
    end

    // Descriptor, result and operand registers.
    always_comb begin
        base_d        = accept ? cmd_base : base_q;
        len_d         = accept ? cmd_len : len_q;
        float_int_d   = accept ? cmd_float_int : float_int_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        if (accept) begin
            res_data_d    = '0;
            res_timeout_d = 1'b0;
        end else begin
            if (pulse_inc) begin
                res_data_d = mac_out;
            end
            if (timed_out && !pulse_final) begin
                res_timeout_d = 1'b1;
            end
        end
        in_valid_d = rd_en;
        in_a_d     = rd_en ? rd_data_a : in_a_q;
        in_b_d     = rd_en ? rd_data_b : in_b_q;
    end

    assign cmd_ready_d = (state_d == StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cmd_ready_q   <= 1'b0;
            base_q        <= '0;
            len_q         <= '0;
            float_int_q   <= 1'b0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            in_a_q        <= '0;
            in_b_q        <= '0;
            in_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            base_q        <= base_d;
            len_q         <= len_d;
            float_int_q   <= float_int_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
            in_a_q        <= in_a_d;
            in_b_q        <= in_b_d;
            in_valid_q    <= in_valid_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign float_int   = float_int_q;
    assign data_num    = len_q;
    assign in_a        = in_a_q;
    assign in_b        = in_b_q;
    assign in_valid_a  = in_valid_q;
    assign in_valid_b  = in_valid_q;
    assign res_data    = res_data_q;
    assign res_timeout = res_timeout_q;

endmodule
